// File: rtl/rtc_bus_sequencer.sv
// rtl/rtc_bus_sequencer.sv - round-robin write/read sequencer for the RTC multiplexed AD port
//
// Arbitrates single-register write and read requests, then runs one
// address phase followed by one data phase on the RTC pins. Each phase is
// split into setup, strobe and hold sections lasting T_SET, T_STB and T_HLD
// cycles.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   wr_req/wr_addr/wr_data   write request (level, held until wr_ack)
//   wr_ack                   one-cycle pulse when the write has finished
//   rd_req/rd_addr           read request (level, held until rd_ack)
//   rd_ack, rd_data          one-cycle completion pulse, last byte read
//   busy                     high while a transaction is on the pins
//   ad, cs, rd, wr           active-low RTC strobes
//   bus_out, bus_oe, bus_in  RTC data pins: drive value, drive enable, sampled value
module rtc_bus_sequencer #(
  parameter int T_SET = 1,
  parameter int T_STB = 2,
  parameter int T_HLD = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_req,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ack,
  input  logic       rd_req,
  input  logic [7:0] rd_addr,
  output logic       rd_ack,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       ad,
  output logic       cs,
  output logic       rd,
  output logic       wr,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  input  logic [7:0] bus_in
);

  typedef enum logic [2:0] {IDLE, A_SET, A_STB, A_HLD, D_SET, D_STB, D_HLD} state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       cur_rd;
  logic       last_rd;
  logic [7:0] cur_addr;
  logic [7:0] cur_data;

  // On contention the requester not served last wins; otherwise whoever asks.
  logic       pick_rd;
  logic [7:0] pick_addr;
  logic       can_grant;

  assign pick_rd   = rd_req && (!wr_req || !last_rd);
  assign pick_addr = pick_rd ? rd_addr : wr_addr;
  // The ack cycle never grants, so a finished requester has time to drop req.
  assign can_grant = (wr_req || rd_req) && !wr_ack && !rd_ack;

  function automatic logic [3:0] limit(state_t s);
    case (s)
      A_SET, D_SET: limit = T_SET[3:0];
      A_STB, D_STB: limit = T_STB[3:0];
      default:      limit = T_HLD[3:0];
    endcase
  endfunction

  function automatic state_t succ(state_t s);
    case (s)
      A_SET:   succ = A_STB;
      A_STB:   succ = A_HLD;
      A_HLD:   succ = D_SET;
      D_SET:   succ = D_STB;
      D_STB:   succ = D_HLD;
      default: succ = IDLE;
    endcase
  endfunction

  // Pin image {ad, cs, rd, wr, bus_oe, bus_out} of a state. Outputs are loaded
  // with the image of the state being entered, so pins change only on edges.
  // The address strobe is always wr; read data phases never drive the bus.
  function automatic logic [12:0] pins(state_t s, logic is_rd, logic [7:0] a, logic [7:0] d);
    case (s)
      A_SET, A_HLD: pins = {4'b0011, 1'b1, a};
      A_STB:        pins = {4'b0010, 1'b1, a};
      D_SET, D_HLD: pins = is_rd ? {4'b1011, 1'b0, 8'h00} : {4'b1011, 1'b1, d};
      D_STB:        pins = is_rd ? {4'b1001, 1'b0, 8'h00} : {4'b1010, 1'b1, d};
      default:      pins = {4'b1111, 1'b0, 8'h00};
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd1;
      cur_rd   <= 1'b0;
      last_rd  <= 1'b1;
      cur_addr <= 8'h00;
      cur_data <= 8'h00;
      wr_ack   <= 1'b0;
      rd_ack   <= 1'b0;
      rd_data  <= 8'h00;
      busy     <= 1'b0;
      {ad, cs, rd, wr, bus_oe, bus_out} <= {4'b1111, 1'b0, 8'h00};
    end else begin
      wr_ack <= 1'b0;
      rd_ack <= 1'b0;
      if (state == IDLE) begin
        if (can_grant) begin
          state    <= A_SET;
          cnt      <= 4'd1;
          cur_rd   <= pick_rd;
          last_rd  <= pick_rd;
          cur_addr <= pick_addr;
          cur_data <= wr_data;
          busy     <= 1'b1;
          {ad, cs, rd, wr, bus_oe, bus_out} <= pins(A_SET, pick_rd, pick_addr, wr_data);
        end
      end else if (cnt == limit(state)) begin
        cnt <= 4'd1;
        // Capture on the final strobe cycle, while rd is still low.
        if (state == D_STB && cur_rd) begin
          rd_data <= bus_in;
        end
        if (state == D_HLD) begin
          state  <= IDLE;
          busy   <= 1'b0;
          wr_ack <= !cur_rd;
          rd_ack <= cur_rd;
        end else begin
          state <= succ(state);
        end
        {ad, cs, rd, wr, bus_oe, bus_out} <= pins(succ(state), cur_rd, cur_addr, cur_data);
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// tb/tb_rtc_bus_sequencer.sv - bench for rtc_bus_sequencer (default and 3/5/2 timing instances)
module tb_rtc_bus_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       wr_req [2];
  logic [7:0] wr_addr [2];
  logic [7:0] wr_data [2];
  logic       rd_req [2];
  logic [7:0] rd_addr [2];
  logic [7:0] bus_in [2];
  logic       wr_ack [2];
  logic       rd_ack [2];
  logic [7:0] rd_data [2];
  logic       busy [2];
  logic       ad_p [2];
  logic       cs_p [2];
  logic       rd_p [2];
  logic       wr_p [2];
  logic [7:0] bus_out [2];
  logic       bus_oe [2];

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  rtc_bus_sequencer u0 (
    .clk(clk), .rst(rst),
    .wr_req(wr_req[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]), .wr_ack(wr_ack[0]),
    .rd_req(rd_req[0]), .rd_addr(rd_addr[0]), .rd_ack(rd_ack[0]), .rd_data(rd_data[0]),
    .busy(busy[0]), .ad(ad_p[0]), .cs(cs_p[0]), .rd(rd_p[0]), .wr(wr_p[0]),
    .bus_out(bus_out[0]), .bus_oe(bus_oe[0]), .bus_in(bus_in[0])
  );

  rtc_bus_sequencer #(.T_SET(3), .T_STB(5), .T_HLD(2)) u1 (
    .clk(clk), .rst(rst),
    .wr_req(wr_req[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]), .wr_ack(wr_ack[1]),
    .rd_req(rd_req[1]), .rd_addr(rd_addr[1]), .rd_ack(rd_ack[1]), .rd_data(rd_data[1]),
    .busy(busy[1]), .ad(ad_p[1]), .cs(cs_p[1]), .rd(rd_p[1]), .wr(wr_p[1]),
    .bus_out(bus_out[1]), .bus_oe(bus_oe[1]), .bus_in(bus_in[1])
  );

  // Model: a transaction is a run of 2*(S+B+H) cycles indexed by t; within each
  // half, cycles S..S+B-1 are the strobe. Arbitration per the request rules.
  int         ts [2] = '{1, 3};
  int         tb [2] = '{2, 5};
  int         th [2] = '{1, 2};
  bit         m_act [2];
  int         m_t [2];
  bit         m_rd [2];
  bit         m_last_rd [2];
  bit         m_wack [2];
  bit         m_rack [2];
  logic [7:0] m_addr [2];
  logic [7:0] m_data [2];
  logic [7:0] m_rdd [2];

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      int p;
      p = ts[i] + tb[i] + th[i];
      if (rst) begin
        m_act[i] = 0; m_t[i] = 0; m_wack[i] = 0; m_rack[i] = 0;
        m_rdd[i] = 8'h00; m_last_rd[i] = 1; m_rd[i] = 0;
        m_addr[i] = 8'h00; m_data[i] = 8'h00;
      end else if (m_act[i]) begin
        if (m_rd[i] && m_t[i] == p + ts[i] + tb[i] - 1) m_rdd[i] = bus_in[i];
        if (m_t[i] == 2 * p - 1) begin
          m_act[i] = 0; m_wack[i] = !m_rd[i]; m_rack[i] = m_rd[i];
        end else begin
          m_t[i] = m_t[i] + 1;
        end
      end else if (m_wack[i] || m_rack[i]) begin
        m_wack[i] = 0; m_rack[i] = 0;
      end else if (wr_req[i] || rd_req[i]) begin
        m_rd[i] = (wr_req[i] && rd_req[i]) ? !m_last_rd[i] : rd_req[i];
        m_last_rd[i] = m_rd[i];
        m_addr[i] = m_rd[i] ? rd_addr[i] : wr_addr[i];
        m_data[i] = wr_data[i];
        m_act[i] = 1; m_t[i] = 0;
      end
    end
  end

  // {ad, cs, rd, wr, bus_oe, bus_out, busy, wr_ack, rd_ack, rd_data}
  function automatic logic [23:0] exp_vec(int i);
    int  p, u;
    bit  stb;
    p = ts[i] + tb[i] + th[i];
    u = m_t[i] % p;
    stb = (u >= ts[i]) && (u < ts[i] + tb[i]);
    if (!m_act[i])
      exp_vec = {4'b1111, 1'b0, 8'h00, 1'b0, m_wack[i], m_rack[i], m_rdd[i]};
    else if (m_t[i] < p)
      exp_vec = {1'b0, 1'b0, 1'b1, !stb, 1'b1, m_addr[i], 3'b100, m_rdd[i]};
    else if (m_rd[i])
      exp_vec = {1'b1, 1'b0, !stb, 1'b1, 1'b0, 8'h00, 3'b100, m_rdd[i]};
    else
      exp_vec = {1'b1, 1'b0, 1'b1, !stb, 1'b1, m_data[i], 3'b100, m_rdd[i]};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        logic [23:0] e, a;
        e = exp_vec(i);
        a = {ad_p[i], cs_p[i], rd_p[i], wr_p[i], bus_oe[i], bus_out[i],
             busy[i], wr_ack[i], rd_ack[i], rd_data[i]};
        tests_run++;
        if (a !== e) begin
          tests_failed++;
          $display("FAIL cycle_model inst%0d at %0t: actual=%h required=%h", i, $time, a, e);
        end
      end
    end
  end

  task automatic chk(input string name, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: actual=%0d (0x%0h) required=%0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    int n, lat, c1, c2, c3, v, acks, order, idle, found, wack, bstart;
    bit drop_w, drop_r, prev_busy;
    for (int i = 0; i < 2; i++) begin
      wr_req[i] = 0; rd_req[i] = 0; wr_addr[i] = 0; wr_data[i] = 0;
      rd_addr[i] = 0; bus_in[i] = 0;
    end
    do_reset();
    @(negedge clk);
    chk("reset_rd_data", rd_data[0], 0);
    chk("reset_pins", {ad_p[0], cs_p[0], rd_p[0], wr_p[0], bus_oe[0], busy[0]}, 6'b111100);

    // Single write.
    wr_addr[0] = 8'h21; wr_data[0] = 8'h59; wr_req[0] = 1;
    lat = -1; c1 = 0; c2 = 0; v = 0;
    for (n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (!ad_p[0]) c1++;
      if (!wr_p[0]) c2++;
      if (!wr_p[0] && ad_p[0] && !cs_p[0]) v = bus_out[0];
      if (wr_ack[0] && lat < 0) begin lat = n; wr_req[0] = 0; end
    end
    chk("wr_latency", lat, 9);
    chk("wr_ad_low_cycles", c1, 4);
    chk("wr_strobe_low_cycles", c2, 4);
    chk("wr_data_bus", v, 8'h59);

    // Single read.
    rd_addr[0] = 8'h24; bus_in[0] = 8'h17; rd_req[0] = 1;
    lat = -1; c1 = 0; c2 = 0; v = -1;
    for (n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (!rd_p[0]) c1++;
      if (!rd_p[0] && bus_oe[0]) c2++;
      if (rd_ack[0] && lat < 0) begin lat = n; v = rd_data[0]; rd_req[0] = 0; bus_in[0] = 8'h99; end
    end
    chk("rd_latency", lat, 9);
    chk("rd_strobe_low_cycles", c1, 2);
    chk("rd_strobe_with_oe", c2, 0);
    chk("rd_data_at_ack", v, 8'h17);
    chk("rd_data_held", rd_data[0], 8'h17);

    // Contention from reset: W, R, W, R with one idle cycle between.
    do_reset();
    wr_addr[0] = 8'h30; wr_data[0] = 8'h01; rd_addr[0] = 8'h31; bus_in[0] = 8'h5A;
    wr_req[0] = 1; rd_req[0] = 1;
    acks = 0; order = 0; idle = 0; drop_w = 0; drop_r = 0; prev_busy = 0;
    for (n = 0; n < 80 && acks < 4; n++) begin
      @(negedge clk);
      if (drop_w) begin drop_w = 0; if (acks < 3) wr_req[0] = 1; end
      if (drop_r) begin drop_r = 0; if (acks < 3) rd_req[0] = 1; end
      if (busy[0] && !prev_busy && acks > 0) begin chk("rr_idle_gap", idle, 1); idle = 0; end
      if (!busy[0] && !wr_ack[0] && !rd_ack[0]) idle++;
      if (wr_ack[0]) begin acks++; order = order * 10 + 1; wr_req[0] = 0; drop_w = 1; end
      if (rd_ack[0]) begin acks++; order = order * 10 + 2; rd_req[0] = 0; drop_r = 1; end
      prev_busy = busy[0];
    end
    chk("rr_order_w1r2", order, 1212);
    wr_req[0] = 0; rd_req[0] = 0;
    repeat (3) @(negedge clk);

    // Slow-timing read on instance 1; bus_in changes every cycle.
    rd_addr[1] = 8'h42; rd_req[1] = 1;
    lat = -1; c1 = 0; c2 = 0; c3 = 0; v = -1;
    for (n = 1; n <= 40; n++) begin
      @(negedge clk);
      bus_in[1] = 8'h40 + 8'(n);
      if (!rd_p[1]) begin c1++; if (c1 == 5) v = bus_in[1]; end
      if (!wr_p[1]) c2++;
      if (!ad_p[1]) c3++;
      if (rd_ack[1] && lat < 0) begin lat = n; rd_req[1] = 0; chk("slow_rd_data", rd_data[1], v); end
    end
    chk("slow_latency", lat, 21);
    chk("slow_rd_low", c1, 5);
    chk("slow_addr_strobe_low", c2, 5);
    chk("slow_ad_low", c3, 10);

    // Read requested during a write's address strobe, then rd_addr disturbed.
    @(negedge clk);
    wr_addr[0] = 8'h05; wr_data[0] = 8'hA5; wr_req[0] = 1; rd_addr[0] = 8'h33; bus_in[0] = 8'h6C;
    wack = -1; bstart = -1; v = -1;
    for (n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (wack < 0 && !wr_p[0] && !ad_p[0]) rd_req[0] = 1;
      if (wr_ack[0] && wack < 0) begin wack = n; wr_req[0] = 0; end
      if (wack > 0 && bstart < 0 && busy[0]) bstart = n;
      if (bstart > 0 && !ad_p[0]) v = bus_out[0];
      if (bstart > 0 && !rd_p[0]) rd_addr[0] = 8'hEE;
      if (rd_ack[0]) rd_req[0] = 0;
    end
    chk("queued_rd_start", bstart - wack, 2);
    chk("queued_rd_addr", v, 8'h33);

    // Reset during the data strobe of a write.
    @(negedge clk);
    wr_addr[0] = 8'h10; wr_data[0] = 8'h99; wr_req[0] = 1;
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      @(negedge clk);
      if (!wr_p[0] && ad_p[0]) found = 1;
    end
    chk("abort_reached_dstb", found, 1);
    rst = 1'b1;
    #1;
    chk("abort_pins", {wr_p[0], cs_p[0], bus_oe[0], busy[0]}, 4'b1100);
    wr_req[0] = 0;
    @(negedge clk); rst = 1'b0;
    found = 0;
    repeat (15) begin
      @(negedge clk);
      if (wr_ack[0]) found = 1;
    end
    chk("abort_no_ack", found, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
